// File: rtl/curr_ctrl_debug_capture.sv
// Trace-capture engine: streams decimated samples into a circular debug RAM
// through a write-only port, with pre-/post-trigger framing of the record.
module curr_ctrl_debug_capture #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [7:0]        decim,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              trigger,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_writedata,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  output logic [1:0]        state,
  output logic              done,
  output logic              irq,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [7:0]          decim_cnt_q, decim_cnt_d;
  logic [ADDR_W-1:0]   post_rem_q, post_rem_d;
  logic [ADDR_W-1:0]   post_l_q, post_l_d;
  logic [7:0]          decim_l_q, decim_l_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
  logic [DATA_W-1:0]   ram_writedata_q, ram_writedata_d;
  logic                ram_write_q, ram_write_d;
  logic                irq_q, irq_d;
  logic                done_q, done_d;

  logic                active, valid_act, cap, enter_done;
  logic [ADDR_W-1:0]   pre_req;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    fill_cnt_d      = fill_cnt_q;
    decim_cnt_d     = decim_cnt_q;
    post_rem_d      = post_rem_q;
    post_l_d        = post_l_q;
    decim_l_d       = decim_l_q;
    trig_addr_d     = trig_addr_q;
    start_addr_d    = start_addr_q;
    ram_address_d   = ram_address_q;
    ram_writedata_d = ram_writedata_q;
    ram_write_d     = 1'b0;
    irq_d           = 1'b0;
    done_d          = done_q;
    enter_done      = 1'b0;

    active    = (state_q == ARMED) || (state_q == POST);
    // An abort cycle launches no new write; a write registered earlier still lands.
    valid_act = sample_valid && active && !abort;
    cap       = valid_act && (decim_cnt_q == 8'd0);
    pre_req   = MAX_CNT - post_l_q;

    if (valid_act)
      decim_cnt_d = (decim_cnt_q == 8'd0) ? decim_l_q : decim_cnt_q - 8'd1;

    if (cap) begin
      ram_write_d     = 1'b1;
      ram_address_d   = wr_ptr_q;
      ram_writedata_d = sample_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      fill_cnt_d      = (fill_cnt_q == MAX_CNT) ? fill_cnt_q : fill_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (arm && !abort) begin
          post_l_d    = post_count;
          decim_l_d   = decim;
          wr_ptr_d    = '0;
          fill_cnt_d  = '0;
          decim_cnt_d = '0;
          done_d      = 1'b0;
          state_d     = ARMED;
        end
      end
      ARMED: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cap && trigger && (fill_cnt_q >= pre_req)) begin
          trig_addr_d = wr_ptr_q;
          post_rem_d  = post_l_q;
          if (post_l_q == '0) enter_done = 1'b1;
          else                state_d    = POST;
        end
      end
      POST: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cap) begin
          post_rem_d = post_rem_q - 1'b1;
          if (post_rem_q == ADDR_W'(1)) enter_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // DONE is always entered on a capture, so the oldest sample sits just past it.
    if (enter_done) begin
      state_d      = DONE;
      done_d       = 1'b1;
      irq_d        = 1'b1;
      start_addr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      fill_cnt_q      <= '0;
      decim_cnt_q     <= '0;
      post_rem_q      <= '0;
      post_l_q        <= '0;
      decim_l_q       <= '0;
      trig_addr_q     <= '0;
      start_addr_q    <= '0;
      ram_address_q   <= '0;
      ram_writedata_q <= '0;
      ram_write_q     <= 1'b0;
      irq_q           <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      fill_cnt_q      <= fill_cnt_d;
      decim_cnt_q     <= decim_cnt_d;
      post_rem_q      <= post_rem_d;
      post_l_q        <= post_l_d;
      decim_l_q       <= decim_l_d;
      trig_addr_q     <= trig_addr_d;
      start_addr_q    <= start_addr_d;
      ram_address_q   <= ram_address_d;
      ram_writedata_q <= ram_writedata_d;
      ram_write_q     <= ram_write_d;
      irq_q           <= irq_d;
      done_q          <= done_d;
    end
  end

  assign ram_address    = ram_address_q;
  assign ram_writedata  = ram_writedata_q;
  assign ram_byteenable = 4'hF;
  assign ram_chipselect = ram_write_q;
  assign ram_write      = ram_write_q;
  assign ram_clken      = 1'b1;
  assign state          = state_q;
  assign done           = done_q;
  assign irq            = irq_q;
  assign trig_addr      = trig_addr_q;
  assign start_addr     = start_addr_q;

endmodule

// File: doc/curr_ctrl_debug_capture.md
Name: curr_ctrl_debug_capture

Overview:
- Trace-capture engine for the current-control debug path. It sits directly upstream of the 512x32 dual-port debug RAM and drives that RAM's second port (s2) as a write-only master.
- It streams decimated 32-bit control-loop samples into the RAM as a circular buffer, with pre-/post-trigger control.
- After capture, the CPU reads the frozen record through port s1, using the reported trigger and start addresses.

Parameters:
- ADDR_W, 9, RAM address width.
- DEPTH, 512, RAM depth in words; must equal 2**ADDR_W.
- DATA_W, 32, sample and RAM data width.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  start-capture pulse.
- abort  in  1  cancel-capture pulse.
- post_count  in  9  number of samples to write after the trigger sample (0..511); latched on arm.
- decim  in  8  decimation; one sample is written per (decim+1) valid samples; latched on arm.
- sample_valid  in  1  sample_data qualifier.
- sample_data  in  32  control-loop sample.
- trigger  in  1  level input, sampled only on capture strobes.
- ram_address  out  9  to RAM address2.
- ram_writedata  out  32  to RAM writedata2.
- ram_byteenable  out  4  constant 4'hF.
- ram_chipselect  out  1  to RAM chipselect2; equal to ram_write.
- ram_write  out  1  to RAM write2.
- ram_clken  out  1  constant 1.
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- done  out  1  high while in DONE.
- irq  out  1  one-cycle pulse on entry to DONE.
- trig_addr  out  9  RAM address of the trigger sample.
- start_addr  out  9  oldest sample address (the write pointer on DONE entry).

Behaviour:
- Reset values: all outputs 0 except ram_byteenable=4'hF and ram_clken=1. Internal wr_ptr, fill_cnt, decim_cnt and post_rem are also 0.
- Capture strobe: cap = sample_valid & (decim_cnt==0) & state is ARMED or POST.
  - On each valid sample in these states, decim_cnt reloads to decim_l when it is 0; otherwise it decrements.
- Write latency: when cap is high in cycle N, the cycle N+1 outputs are ram_write=ram_chipselect=1, ram_address=wr_ptr and ram_writedata=that sample.
  - wr_ptr then increments modulo DEPTH (511 wraps to 0).
  - ram_write is 0 in every cycle with no prior cap.
- fill_cnt counts writes since arm and saturates at 511. pre_req = DEPTH-1-post_l.
- IDLE / DONE:
  - arm latches post_l and decim_l.
  - It clears wr_ptr, fill_cnt and decim_cnt, clears done, and moves to ARMED.
  - trig_addr and start_addr hold their values until the next trigger.
- ARMED: on cap & trigger & (fill_cnt >= pre_req), that sample is the trigger sample.
  - trig_addr <= wr_ptr; post_rem <= post_l.
  - Next state is POST, or DONE when post_l == 0.
  - trigger while fill_cnt < pre_req is ignored, and the sample is still written.
- POST: each cap writes the sample and decrements post_rem. The cap that brings post_rem to 0 moves the block to DONE. trigger is ignored.
- DONE entry:
  - start_addr <= wr_ptr value after the final write; the buffer is complete, so this is the oldest sample.
  - irq pulses for 1 cycle; done=1.
  - No further writes occur; the final write completes in the entry cycle.
- arm in ARMED or POST is ignored.
- abort in ARMED or POST moves the block to IDLE next cycle.
  - Any write already registered for that cycle still completes; no new writes follow.
  - irq does not fire, and done stays 0.
- Simultaneous arm & abort: abort wins.
- Asynchronous reset mid-capture: all registers return to reset values immediately, and ram_write drops without waiting for a clock.

Test Plan:
- Pre-fill and wrap: post_count=100, decim=0; sample_data=index with valid every cycle; trigger=1 at sample 600 only.
  - Required: trig_addr=88; 100 more writes; irq on the write of sample 700; start_addr=189; RAM[88]=600.
- Early trigger ignored: post_count=500 (pre_req=11); trigger pulses on sample 10, then on sample 11.
  - Required: sample 10 is ignored; sample 11 is accepted, so trig_addr=11 and state=POST.
- Decimation: decim=3, valid every cycle, sample_data=index.
  - Required: ram_write is high every 4th cycle; writedata is 0,4,8,…; ram_address is 0,1,2,….
  - Required: the first write appears 1 cycle after the first valid.
- post_count=0, after the pre-fill is satisfied: trigger on one sample.
  - Required: DONE is entered with that write; start_addr=trig_addr+1; irq is 1 cycle wide.
- Abort mid-POST: abort during POST.
  - Required: state=IDLE next cycle; no writes after the pending one; irq stays 0.
  - Required: a subsequent arm restarts at ram_address=0.
- Reset asserted mid-POST, asynchronously between clock edges.
  - Required: ram_write=0 and state=IDLE before the next edge.
